// File: rtl/uart_pkg.sv
// uart_pkg: arbiter state encoding and the byte-width/timeout defaults shared by the UART blocks.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_TIMEOUT_CYCLES = 2000000;
  typedef enum logic [1:0] {IDLE, START, WAIT} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set valid bit at or after ptr with wrap.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[(int'(ptr) + k) % N]) begin
        grant = '0;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx between NUM_REQ byte sources, with a WAIT watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = UART_DATA_W,
  parameter int TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [IW-1:0]             grant_id,
  output logic                      timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  arb_state_t state, nstate;
  logic [IW-1:0] rr_ptr, pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic [CW-1:0] wd;
  logic wd_exp, leave;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .valid(req_valid),
    .ptr(rr_ptr),
    .grant(pick_grant),
    .idx(pick_idx)
  );
  assign wd_exp = state == WAIT && !tx_done && wd == CW'(TIMEOUT_CYCLES - 1);
  assign leave = state == WAIT && (tx_done || wd_exp);
  always_comb begin
    nstate = state;
    req_ready = '0;
    tx_start = 1'b0;
    case (state)
      IDLE: begin
        req_ready = reset ? '0 : pick_grant;
        nstate = |req_valid ? START : IDLE;
      end
      START: begin
        tx_start = !reset && !tx_busy;
        nstate = tx_busy ? START : WAIT;
      end
      WAIT: nstate = leave ? IDLE : WAIT;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      tx_data <= '0;
      grant_id <= '0;
      timeout_err <= 1'b0;
      wd <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE && |req_valid) begin
        tx_data <= req_data[pick_idx*DATA_W +: DATA_W];
        grant_id <= pick_idx;
      end
      wd <= state == WAIT ? wd + 1'b1 : '0;
      if (wd_exp) timeout_err <= 1'b1;
      if (leave) rr_ptr <= grant_id == IW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed checks against a transaction-level arbiter model.
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, T = 16;
  logic clk = 0, reset = 1, tx_busy = 0, tx_done = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] req_data = '0;
  logic [W-1:0] tx_data;
  logic tx_start, timeout_err;
  logic [1:0] grant_id;
  int checks = 0, errors = 0;
  int m_phase = 0, m_ptr = 0, m_gid = 0, m_wait = 0;
  logic [W-1:0] m_txd = '0;
  bit m_terr = 0, started = 0, refill = 0, rnd = 0;
  int acc = -1, lat_cnt = 0, done_lat = 10;
  int starts[$];
  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic run_cycle();
    logic [N-1:0] er;
    int w;
    #4;
    er = '0;
    w = -1;
    if (!reset && m_phase == 0)
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    if (w >= 0) er[w] = 1'b1;
    acc = w;
    started = !reset && m_phase == 1 && !tx_busy;
    check("ready", req_ready, er);
    check("start", tx_start, started);
    check("gid", grant_id, m_gid);
    check("data", tx_data, m_txd);
    check("terr", timeout_err, m_terr);
    if (started) starts.push_back(m_gid);
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_gid = 0; m_txd = '0; m_terr = 0; m_wait = 0;
    end else if (m_phase == 0 && acc >= 0) begin
      m_txd = req_data[acc*W +: W];
      m_gid = acc;
      m_phase = 1;
    end else if (m_phase == 1 && !tx_busy) begin
      m_phase = 2;
      m_wait = 0;
    end else if (m_phase == 2) begin
      m_wait++;
      if (tx_done || m_wait == T) begin
        if (!tx_done) m_terr = 1;
        m_phase = 0;
        m_ptr = (m_gid + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic env_update();
    tx_done = 0;
    if (started) begin
      if (rnd) done_lat = $urandom_range(1, 20);
      lat_cnt = done_lat;
      tx_busy = done_lat != 0;
    end
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin tx_done = 1; tx_busy = 0; end
    end
    if (acc >= 0) begin
      if (refill) req_data[acc*W +: W] = W'($urandom);
      else req_valid[acc] = 0;
    end
    if (rnd)
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(3) == 0) begin
          req_valid[i] = 1;
          req_data[i*W +: W] = W'($urandom);
        end
  endtask
  task automatic run(int n);
    for (int c = 0; c < n; c++) begin env_update(); run_cycle(); end
  endtask
  initial begin
    @(posedge clk);
    #1;
    req_valid = '1;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int c = 0; c < 3; c++) run_cycle();
    req_valid = '0;
    reset = 0;
    run(2);
    req_valid = 4'b0100;
    req_data[2*W +: W] = 8'h41;
    run_cycle();
    run(1);
    check("t2_started", started, 1);
    check("t2_data", tx_data, 8'h41);
    check("t2_gid", grant_id, 2);
    run(15);
    reset = 1;
    run(1);
    reset = 0;
    starts.delete();
    refill = 1;
    req_valid = '1;
    for (int c = 0; c < 200 && starts.size() < 5; c++) run(1);
    check("t3_count", starts.size(), 5);
    for (int i = 0; i < 5; i++) check("t3_order", starts[i], i % N);
    refill = 0;
    req_valid = '0;
    run(20);
    req_valid = 4'b0010;
    req_data[W +: W] = 8'h5a;
    for (int c = 0; c < 10 && acc < 0; c++) run(1);
    for (int c = 0; c < 5; c++) begin env_update(); tx_busy = 1; run_cycle(); end
    env_update();
    tx_busy = 0;
    run_cycle();
    check("t4_start_once", started, 1);
    run(15);
    starts.delete();
    done_lat = 0;
    req_valid = 4'b1100;
    req_data[3*W +: 2*W] = 16'hbeef;
    run(45);
    check("t5_terr", timeout_err, 1);
    check("t5_count", starts.size(), 2);
    check("t5_first", starts[0], 2);
    check("t5_second", starts[1], 3);
    done_lat = 10;
    req_valid = 4'b0001;
    acc = -1;
    for (int c = 0; c < 10 && !started; c++) run(1);
    run(4);
    env_update();
    reset = 1;
    run_cycle();
    reset = 0;
    env_update();
    req_valid = '0;
    tx_done = 1;
    run_cycle();
    check("t6_terr", timeout_err, 0);
    check("t6_data", tx_data, 0);
    starts.delete();
    req_valid = 4'b0101;
    run(20);
    check("t6_first", starts[0], 0);
    rnd = 1;
    run(800);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
